// File: rtl/instruction_sequencer.sv
// Multi-cycle controller for the 16-bit datapath: fetches, decodes and drives every
// datapath control input through IDLE/FETCH/EXEC/MEM/HALT, with halt/illegal/retired status.
module instruction_sequencer #(
    parameter logic [3:0] ALU_ADD = 4'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] current_instruction,
    input  logic [15:0] zeroflag,
    input  logic [15:0] signflag,
    output logic        program_counter_increment,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic        alu_a_source,
    output logic        alu_b_source,
    output logic [15:0] alu_a_altern,
    output logic [15:0] alu_b_altern,
    output logic [3:0]  alu_out_select,
    output logic [1:0]  alu_load_src,
    output logic        alu_store_to_mem,
    output logic        alu_store_to_stk,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retired
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_PUSH = 4'h5;
    localparam logic [3:0] OP_BZ   = 4'h6;
    localparam logic [3:0] OP_BN   = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic        pc_inc;
        logic [3:0]  op;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic        a_src;
        logic        b_src;
        logic [15:0] a_alt;
        logic [15:0] b_alt;
        logic [3:0]  out_sel;
        logic [1:0]  load_src;
        logic        st_mem;
        logic        st_stk;
    } ctrl_t;

    logic [2:0]  state_q, state_d;
    logic [3:0]  ir_op_q, ir_op_d;
    ctrl_t       ctrl_q, ctrl_d, dec;
    logic [15:0] retired_q, retired_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;

    logic [3:0] f_op, f_rd, f_ra;
    logic [7:0] f_imm;
    logic       taken;

    assign f_op  = current_instruction[15:12];
    assign f_rd  = current_instruction[11:8];
    assign f_ra  = current_instruction[7:4];
    assign f_imm = current_instruction[7:0];

    // Controls are registered, so decode works on the word being fetched; only the
    // opcode is retained for the EXEC/MEM sequencing decisions.
    always_comb begin
        dec   = '0;
        taken = 1'b0;
        case (f_op)
            OP_NOP: dec.pc_inc = 1'b1;
            OP_ALU: begin
                dec.op       = current_instruction[3:0];
                dec.a_sel    = f_rd;
                dec.b_sel    = f_ra;
                dec.out_sel  = f_rd;
                dec.load_src = 2'b01;
                dec.pc_inc   = (f_rd != 4'd0);
            end
            OP_LDI: begin
                dec.a_src    = 1'b1;
                dec.b_src    = 1'b1;
                dec.a_alt    = {8'h00, f_imm};
                dec.op       = ALU_ADD;
                dec.out_sel  = f_rd;
                dec.load_src = 2'b01;
                dec.pc_inc   = (f_rd != 4'd0);
            end
            OP_LD, OP_ST, OP_PUSH: begin
                dec.a_sel   = f_ra;
                dec.b_src   = 1'b1;
                dec.op      = ALU_ADD;
                dec.out_sel = f_rd;
                dec.st_mem  = (f_op == OP_ST);
                dec.st_stk  = (f_op == OP_PUSH);
                dec.pc_inc  = (f_op != OP_LD) || (f_rd != 4'd0);
            end
            OP_BZ, OP_BN: begin
                taken = (f_op == OP_BZ) ? zeroflag[f_rd] : signflag[f_rd];
                if (taken) begin
                    dec.b_src    = 1'b1;
                    dec.b_alt    = {{8{f_imm[7]}}, f_imm};
                    dec.op       = ALU_ADD;
                    dec.load_src = 2'b01;
                end else begin
                    dec.pc_inc = 1'b1;
                end
            end
            OP_HALT: dec = '0;
            default: dec.pc_inc = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_op_d   = ir_op_q;
        ctrl_d    = '0;
        retired_d = retired_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                    ir_op_d = f_op;
                    ctrl_d  = dec;
                    if (f_op inside {[4'h8:4'hE]}) illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (ir_op_q == OP_LD) begin
                    state_d         = S_MEM;
                    ctrl_d          = ctrl_q;
                    ctrl_d.load_src = 2'b10;
                    ctrl_d.pc_inc   = 1'b0;
                end else begin
                    retired_d = retired_q + 16'd1;
                    if (ir_op_q == OP_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_MEM: begin
                state_d   = S_FETCH;
                retired_d = retired_q + 16'd1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_op_q   <= '0;
            ctrl_q    <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_op_q   <= ir_op_d;
            ctrl_q    <= ctrl_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign program_counter_increment = ctrl_q.pc_inc;
    assign alu_op           = ctrl_q.op;
    assign alu_a_select     = ctrl_q.a_sel;
    assign alu_b_select     = ctrl_q.b_sel;
    assign alu_a_source     = ctrl_q.a_src;
    assign alu_b_source     = ctrl_q.b_src;
    assign alu_a_altern     = ctrl_q.a_alt;
    assign alu_b_altern     = ctrl_q.b_alt;
    assign alu_out_select   = ctrl_q.out_sel;
    assign alu_load_src     = ctrl_q.load_src;
    assign alu_store_to_mem = ctrl_q.st_mem;
    assign alu_store_to_stk = ctrl_q.st_stk;
    assign halted           = halted_q;
    assign illegal          = illegal_q;
    assign retired          = retired_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: an instruction-level model queues the
// expected per-cycle output frames, and a negedge monitor compares them with the DUT.
module tb_instruction_sequencer;

    localparam logic [3:0] ALU_ADD = 4'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] current_instruction;
    logic [15:0] zeroflag;
    logic [15:0] signflag;
    logic        program_counter_increment;
    logic [3:0]  alu_op, alu_a_select, alu_b_select, alu_out_select;
    logic        alu_a_source, alu_b_source;
    logic [15:0] alu_a_altern, alu_b_altern;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_mem, alu_store_to_stk;
    logic        halted, illegal;
    logic [15:0] retired;

    instruction_sequencer #(.ALU_ADD(ALU_ADD)) dut (
        .clock(clock), .reset(reset), .run(run),
        .current_instruction(current_instruction),
        .zeroflag(zeroflag), .signflag(signflag),
        .program_counter_increment(program_counter_increment),
        .alu_op(alu_op), .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
        .alu_a_source(alu_a_source), .alu_b_source(alu_b_source),
        .alu_a_altern(alu_a_altern), .alu_b_altern(alu_b_altern),
        .alu_out_select(alu_out_select), .alu_load_src(alu_load_src),
        .alu_store_to_mem(alu_store_to_mem), .alu_store_to_stk(alu_store_to_stk),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        pc_inc;
        logic [3:0]  op;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic        a_src;
        logic        b_src;
        logic [15:0] a_alt;
        logic [15:0] b_alt;
        logic [3:0]  out_sel;
        logic [1:0]  load;
        logic        st_mem;
        logic        st_stk;
        logic        halted;
        logic        illegal;
        logic [15:0] retired;
    } frame_t;

    frame_t exp_q[$];
    string  name_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    logic [15:0] m_retired;
    logic        m_halted, m_illegal;
    frame_t      got_exec, got_mem;

    function automatic frame_t cur();
        frame_t a;
        a.pc_inc = program_counter_increment; a.op = alu_op;
        a.a_sel = alu_a_select; a.b_sel = alu_b_select;
        a.a_src = alu_a_source; a.b_src = alu_b_source;
        a.a_alt = alu_a_altern; a.b_alt = alu_b_altern;
        a.out_sel = alu_out_select; a.load = alu_load_src;
        a.st_mem = alu_store_to_mem; a.st_stk = alu_store_to_stk;
        a.halted = halted; a.illegal = illegal; a.retired = retired;
        return a;
    endfunction

    // What the instruction asks of the datapath, stated by its meaning
    function automatic frame_t model_exec(input logic [15:0] w, input logic [15:0] zf,
                                          input logic [15:0] sf);
        frame_t e;
        logic [3:0] op, rd, ra;
        bit writes_reg, taken;
        e = '0;
        op = w[15:12]; rd = w[11:8]; ra = w[7:4];
        writes_reg = 0; taken = 0;
        if (op == 4'd1) begin
            e.op = w[3:0]; e.a_sel = rd; e.b_sel = ra; e.out_sel = rd; e.load = 2'b01;
            writes_reg = 1;
        end else if (op == 4'd2) begin
            e.a_src = 1; e.b_src = 1; e.a_alt = {8'h00, w[7:0]}; e.op = ALU_ADD;
            e.out_sel = rd; e.load = 2'b01; writes_reg = 1;
        end else if (op >= 4'd3 && op <= 4'd5) begin
            e.a_sel = ra; e.b_src = 1; e.op = ALU_ADD; e.out_sel = rd;
            e.st_mem = (op == 4'd4); e.st_stk = (op == 4'd5);
            writes_reg = (op == 4'd3);
        end else if (op == 4'd6 || op == 4'd7) begin
            taken = (op == 4'd6) ? zf[rd] : sf[rd];
            if (taken) begin
                e.b_src = 1; e.b_alt = {{8{w[7]}}, w[7:0]}; e.op = ALU_ADD; e.load = 2'b01;
            end
        end
        e.pc_inc = !(taken || op == 4'hF || (writes_reg && rd == 4'd0));
        return e;
    endfunction

    always @(negedge clock) begin
        frame_t e, a;
        string  nm;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a = cur();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, a, e);
            end
        end
    end

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input frame_t ctrl, input string nm);
        frame_t f;
        f = ctrl;
        f.halted = m_halted; f.illegal = m_illegal; f.retired = m_retired;
        @(posedge clock);
        exp_q.push_back(f);
        name_q.push_back(nm);
        #1;
    endtask

    // Entered with the DUT in FETCH; returns with it in FETCH (or HALT)
    task automatic do_instr(input logic [15:0] w, input logic [15:0] zf,
                            input logic [15:0] sf, input bit stall);
        frame_t e, m;
        if (stall) begin
            run = 0; current_instruction = 16'($urandom);
            tick('0, "stall_idle");
            repeat ($urandom_range(0, 2)) tick('0, "stall_idle");
            run = 1;
            tick('0, "refetch");
        end
        run = 1; current_instruction = w; zeroflag = zf; signflag = sf;
        if (w[15:12] >= 4'h8 && w[15:12] <= 4'hE) m_illegal = 1;
        e = model_exec(w, zf, sf);
        tick(e, "exec");
        got_exec = cur();
        run = 1'($urandom_range(0, 1));
        current_instruction = 16'($urandom);
        if (w[15:12] == 4'd3) begin
            m = e; m.load = 2'b10; m.pc_inc = 0;
            tick(m, "mem");
            got_mem = cur();
        end
        m_retired = m_retired + 16'd1;
        if (w[15:12] == 4'hF) m_halted = 1;
        run = 1;
        tick('0, (w[15:12] == 4'hF) ? "halt" : "fetch");
    endtask

    task automatic do_reset(input string nm);
        #5;
        reset = 1;
        #1;
        check(nm, 80'(cur()), 80'd0);
        m_retired = '0; m_halted = 0; m_illegal = 0;
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    initial begin
        logic [15:0] w;
        reset = 1; run = 0; current_instruction = '0; zeroflag = '0; signflag = '0;
        m_retired = '0; m_halted = 0; m_illegal = 0;
        got_exec = '0; got_mem = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", 80'(cur()), 80'd0);
        reset = 0;

        run = 1;
        tick('0, "idle_to_fetch");
        current_instruction = 16'h1123;
        tick(model_exec(16'h1123, '0, '0), "exec_1123");
        do_reset("reset_mid_exec");
        run = 1;
        tick('0, "fetch_after_reset");

        do_instr(16'h21A5, '0, '0, 0);
        check("ldi_exec", {got_exec.a_alt, got_exec.a_src, got_exec.b_src, got_exec.out_sel,
                           got_exec.load, got_exec.pc_inc},
              {16'h00A5, 1'b1, 1'b1, 4'd1, 2'b01, 1'b1});
        check("ldi_retired", 80'(retired), 80'd1);

        do_instr(16'h3240, '0, '0, 0);
        check("ld_exec", {got_exec.a_sel, got_exec.load, got_exec.pc_inc}, {4'd4, 2'b00, 1'b1});
        check("ld_mem", {got_mem.a_sel, got_mem.load, got_mem.pc_inc}, {4'd4, 2'b10, 1'b0});

        do_instr(16'h63FE, 16'h0008, '0, 0);
        check("bz_taken", {got_exec.out_sel, got_exec.b_alt, got_exec.load, got_exec.pc_inc},
              {4'd0, 16'hFFFE, 2'b01, 1'b0});
        do_instr(16'h63FE, 16'hFFF7, 16'hFFFF, 0);
        check("bz_not_taken", {got_exec.load, got_exec.pc_inc}, {2'b00, 1'b1});

        do_instr(16'h2000, '0, '0, 0);
        check("ldi_r0_jump", {got_exec.load, got_exec.out_sel, got_exec.pc_inc},
              {2'b01, 4'd0, 1'b0});

        repeat (400) begin
            w = {4'($urandom_range(0, 14)), 12'($urandom)};
            do_instr(w, 16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
        end

        do_reset("reset_mid_fetch");
        run = 1; current_instruction = '0;
        tick('0, "fetch_after_reset2");
        do_instr(16'h8123, 16'($urandom), 16'($urandom), 0);
        check("illegal_set", 80'(illegal), 80'd1);
        do_instr(16'hF000, '0, '0, 0);
        repeat (5) begin
            run = 1; current_instruction = 16'($urandom);
            tick('0, "halt_stuck");
        end
        check("halted_set", 80'(halted), 80'd1);
        check("retired_two", 80'(retired), 80'd2);

        #5;
        #1;
        check("scoreboard_drained", 80'(exp_q.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
